// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage RISC-V core: drives the data-memory bus, stalls the pipeline
// while the bus is slow, and registers MEM/WB. A request that never completes retires with sticky bus_err.
module memory_access_stage #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               RegWriteM,
   input  logic               ResultSrcM,
   input  logic               MemWriteM,
   input  logic [DATA_W-1:0]  ALUResultM,
   input  logic [DATA_W-1:0]  WriteDataM,
   input  logic [RADDR_W-1:0] RDM,
   input  logic [DATA_W-1:0]  PCPlus4M,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DATA_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic [DATA_W-1:0]  dmem_rdata,
   input  logic               dmem_ready,
   output logic               StallM,
   output logic               bus_err,
   output logic               RegWriteW,
   output logic               ResultSrcW,
   output logic [DATA_W-1:0]  ALUResultW,
   output logic [DATA_W-1:0]  ReadDataW,
   output logic [DATA_W-1:0]  PCPlus4W,
   output logic [RADDR_W-1:0] RDW,
   output logic [DATA_W-1:0]  ResultW,
   output logic               fsm_state
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;

   // Copy of the stalled instruction; drives the bus and retires from here while in WAIT.
   logic               lat_we, lat_regwrite, lat_resultsrc;
   logic [DATA_W-1:0]  lat_alu, lat_wdata, lat_pc4;
   logic [RADDR_W-1:0] lat_rd;

   logic               access, capture, err_set;
   logic               req_raw, we_raw, stall_raw;
   logic [DATA_W-1:0]  addr_raw, wdata_raw;
   logic               wb_regwrite_d, wb_resultsrc_d;
   logic [DATA_W-1:0]  wb_alu_d, wb_read_d, wb_pc4_d;
   logic [RADDR_W-1:0] wb_rd_d;

   assign access = MemWriteM | ResultSrcM;

   // Bus handshake: a request completes in the cycle where dmem_req && dmem_ready; until then
   // dmem_we, dmem_addr and dmem_wdata are held stable by the WAIT copy.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      capture        = 1'b0;
      err_set        = 1'b0;
      req_raw        = 1'b0;
      we_raw         = MemWriteM;
      addr_raw       = ALUResultM;
      wdata_raw      = WriteDataM;
      stall_raw      = 1'b0;
      wb_regwrite_d  = 1'b0;
      wb_resultsrc_d = 1'b0;
      wb_alu_d       = '0;
      wb_read_d      = '0;
      wb_pc4_d       = '0;
      wb_rd_d        = '0;
      case (state)
         IDLE: begin
            req_raw = access;
            if (access && !dmem_ready) begin
               stall_raw  = 1'b1;
               capture    = 1'b1;
               cnt_next   = '0;
               state_next = WAIT;
            end else begin
               wb_regwrite_d  = RegWriteM;
               wb_resultsrc_d = ResultSrcM;
               wb_alu_d       = ALUResultM;
               wb_pc4_d       = PCPlus4M;
               wb_rd_d        = RDM;
               wb_read_d      = (ResultSrcM && dmem_ready) ? dmem_rdata : '0;
            end
         end
         WAIT: begin
            req_raw   = 1'b1;
            we_raw    = lat_we;
            addr_raw  = lat_alu;
            wdata_raw = lat_wdata;
            if (dmem_ready || cnt == CNT_LAST) begin
               // Completion and timeout both retire the held instruction; ready wins a tie.
               wb_regwrite_d  = lat_regwrite;
               wb_resultsrc_d = lat_resultsrc;
               wb_alu_d       = lat_alu;
               wb_pc4_d       = lat_pc4;
               wb_rd_d        = lat_rd;
               wb_read_d      = (dmem_ready && lat_resultsrc) ? dmem_rdata : '0;
               err_set        = !dmem_ready;
               state_next     = IDLE;
            end else begin
               stall_raw = 1'b1;
               cnt_next  = cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bus_err       <= 1'b0;
         lat_we        <= 1'b0;
         lat_regwrite  <= 1'b0;
         lat_resultsrc <= 1'b0;
         lat_alu       <= '0;
         lat_wdata     <= '0;
         lat_pc4       <= '0;
         lat_rd        <= '0;
         RegWriteW     <= 1'b0;
         ResultSrcW    <= 1'b0;
         ALUResultW    <= '0;
         ReadDataW     <= '0;
         PCPlus4W      <= '0;
         RDW           <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (err_set) bus_err <= 1'b1;
         if (capture) begin
            lat_we        <= MemWriteM;
            lat_regwrite  <= RegWriteM;
            lat_resultsrc <= ResultSrcM;
            lat_alu       <= ALUResultM;
            lat_wdata     <= WriteDataM;
            lat_pc4       <= PCPlus4M;
            lat_rd        <= RDM;
         end
         RegWriteW  <= wb_regwrite_d;
         ResultSrcW <= wb_resultsrc_d;
         ALUResultW <= wb_alu_d;
         ReadDataW  <= wb_read_d;
         PCPlus4W   <= wb_pc4_d;
         RDW        <= wb_rd_d;
      end
   end

   // Bus and stall are gated by reset so an access in flight is dropped the instant rst falls.
   assign dmem_req   = rst & req_raw;
   assign dmem_we    = rst & we_raw;
   assign dmem_addr  = rst ? addr_raw : '0;
   assign dmem_wdata = rst ? wdata_raw : '0;
   assign StallM     = rst & stall_raw;
   assign ResultW    = ResultSrcW ? ReadDataW : ALUResultW;
   assign fsm_state  = (state == WAIT);

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios plus random back-to-back traffic checked
// against a latency-level model of the MEM stage.
module tb_memory_access_stage;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          RegWriteM, ResultSrcM, MemWriteM;
   logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [RW-1:0] RDM;
   logic          dmem_req, dmem_we;
   logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic          dmem_ready;
   logic          StallM, bus_err, RegWriteW, ResultSrcW;
   logic [DW-1:0] ALUResultW, ReadDataW, PCPlus4W, ResultW;
   logic [RW-1:0] RDW;
   logic          fsm_state;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic          exp_err;
   logic [DW-1:0] exp_q[$];

   typedef struct packed {
      logic          rw, rs, mw;
      logic [RW-1:0] rd;
      logic [DW-1:0] alu, wd, pc4;
   } instr_t;

   typedef struct packed {
      logic [7:0]    stalls, bubbles, bus_bad;
      logic          hung;
      logic          rw, rs, err;
      logic [RW-1:0] rd;
      logic [DW-1:0] alu, rdd, pc4, res;
   } obs_t;

   always #5 clk = ~clk;

   memory_access_stage #(.DATA_W(DW), .RADDR_W(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RDM(RDM), .PCPlus4M(PCPlus4M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .StallM(StallM), .bus_err(bus_err),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RDW(RDW), .ResultW(ResultW),
      .fsm_state(fsm_state)
   );

   // Reference model: the bus offers TO+1 request cycles; ready after k idle cycles
   // succeeds when k <= TO, otherwise the access times out after TO stalls.
   function automatic int model_stalls(instr_t i, int k);
      if (!(i.mw || i.rs)) return 0;
      return (k <= TO) ? k : TO;
   endfunction

   function automatic logic [DW-1:0] model_rdd(instr_t i, int k, logic [DW-1:0] rdata);
      return (i.rs && k <= TO) ? rdata : '0;
   endfunction

   function automatic logic model_timeout(instr_t i, int k);
      return (i.mw || i.rs) && (k > TO);
   endfunction

   function automatic instr_t make_instr(logic rw, logic rs, logic mw, logic [RW-1:0] rd,
                                         logic [DW-1:0] alu, logic [DW-1:0] wd);
      instr_t i;
      i.rw = rw; i.rs = rs; i.mw = mw; i.rd = rd; i.alu = alu; i.wd = wd;
      i.pc4 = $urandom;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      int kind;
      kind = $urandom_range(0, 2);
      return make_instr(kind != 2, kind == 1, kind == 2, RW'($urandom), $urandom, $urandom);
   endfunction

   // Driver: presents one instruction, answers the bus after k not-ready cycles, holds it
   // while StallM is high, and reports what was seen up to and including its retirement.
   task automatic issue(input instr_t in, input int k, input logic [DW-1:0] rdata,
                        input bit perturb, output obs_t o);
      bit access, stalled, done;
      int cyc;
      access = in.mw || in.rs;
      o = '0;
      RegWriteM = in.rw; ResultSrcM = in.rs; MemWriteM = in.mw;
      ALUResultM = in.alu; WriteDataM = in.wd; RDM = in.rd; PCPlus4M = in.pc4;
      cyc = 0;
      done = 1'b0;
      while (!done) begin
         if (!access) begin
            dmem_ready = 1'b1; dmem_rdata = $urandom;
         end else if (cyc == k) begin
            dmem_ready = 1'b1; dmem_rdata = in.mw ? '0 : rdata;
         end else begin
            dmem_ready = 1'b0; dmem_rdata = $urandom;
         end
         @(negedge clk);
         stalled = StallM;
         if (access) begin
            if (dmem_req !== 1'b1 || dmem_we !== in.mw || dmem_addr !== in.alu ||
                dmem_wdata !== in.wd) o.bus_bad = o.bus_bad + 8'd1;
         end else if (dmem_req !== 1'b0) o.bus_bad = o.bus_bad + 8'd1;
         @(posedge clk); #1;
         if (!stalled) begin
            done = 1'b1;
         end else begin
            o.stalls = o.stalls + 8'd1;
            if (RegWriteW === 1'b0) o.bubbles = o.bubbles + 8'd1;
            cyc++;
            if (cyc > 40) begin o.hung = 1'b1; done = 1'b1; end
            if (perturb) begin
               RegWriteM = 1'($urandom); ResultSrcM = 1'($urandom); MemWriteM = 1'($urandom);
               ALUResultM = $urandom; WriteDataM = $urandom; RDM = RW'($urandom);
               PCPlus4M = $urandom;
            end
         end
      end
      o.rw = RegWriteW; o.rs = ResultSrcW; o.rd = RDW; o.alu = ALUResultW;
      o.rdd = ReadDataW; o.pc4 = PCPlus4W; o.res = ResultW; o.err = bus_err;
      dmem_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0;
      ALUResultM = 32'h100; WriteDataM = 32'hA5A5; RDM = 5'd5; PCPlus4M = 32'h8;
      dmem_ready = 1'b0; dmem_rdata = '0;
      exp_err = 1'b0;
      #12;
      n_checks++;
      if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dmem_req); end
      n_checks++;
      if (StallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", StallM); end
      n_checks++;
      if (dmem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", dmem_addr); end
      n_checks++;
      if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus_err); end
      n_checks++;
      if ({RegWriteW, ResultSrcW, RDW, ALUResultW, ReadDataW, PCPlus4W, ResultW} !== '0) begin
         n_fail++;
         $display("FAIL reset_memwb: got rw=%b rd=%0d alu=%h rd=%h pc4=%h res=%h want all 0",
                  RegWriteW, RDW, ALUResultW, ReadDataW, PCPlus4W, ResultW);
      end
      n_checks++;
      if (fsm_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", fsm_state); end
      RegWriteM = 1'b0; ResultSrcM = 1'b0; MemWriteM = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_wait_load();
      obs_t o;
      issue(make_instr(1'b1, 1'b1, 1'b0, 5'd5, 32'h100, 32'h0), 0, 32'hDEADBEEF, 1'b0, o);
      n_checks++;
      if (o.stalls !== 8'd0) begin n_fail++; $display("FAIL zw_stalls: got %0d want 0", o.stalls); end
      n_checks++;
      if (o.rw !== 1'b1 || o.rd !== 5'd5) begin
         n_fail++; $display("FAIL zw_dest: got rw=%b rd=%0d want rw=1 rd=5", o.rw, o.rd);
      end
      n_checks++;
      if (o.res !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_result: got %h want deadbeef", o.res); end
      n_checks++;
      if (o.bus_bad !== 8'd0) begin n_fail++; $display("FAIL zw_bus: got %0d bad cycles want 0", o.bus_bad); end
   endtask

   task automatic test_wait_load();
      obs_t o;
      issue(make_instr(1'b1, 1'b1, 1'b0, 5'd5, 32'h100, 32'h0), 3, 32'hCAFE0123, 1'b0, o);
      n_checks++;
      if (o.stalls !== 8'd3) begin n_fail++; $display("FAIL wl_stalls: got %0d want 3", o.stalls); end
      n_checks++;
      if (o.bubbles !== 8'd3) begin n_fail++; $display("FAIL wl_bubbles: got %0d want 3", o.bubbles); end
      n_checks++;
      if (o.bus_bad !== 8'd0) begin n_fail++; $display("FAIL wl_addr_stable: got %0d bad want 0", o.bus_bad); end
      n_checks++;
      if (o.rd !== 5'd5 || o.rdd !== 32'hCAFE0123) begin
         n_fail++; $display("FAIL wl_retire: got rd=%0d data=%h want rd=5 data=cafe0123", o.rd, o.rdd);
      end
   endtask

   task automatic test_store_perturbed();
      obs_t o;
      issue(make_instr(1'b0, 1'b0, 1'b1, 5'd0, 32'h40, 32'h1234), 2, 32'h0, 1'b1, o);
      n_checks++;
      if (o.stalls !== 8'd2) begin n_fail++; $display("FAIL st_stalls: got %0d want 2", o.stalls); end
      n_checks++;
      if (o.bus_bad !== 8'd0) begin n_fail++; $display("FAIL st_bus_held: got %0d bad want 0", o.bus_bad); end
      n_checks++;
      if (o.rw !== 1'b0 || o.alu !== 32'h40) begin
         n_fail++; $display("FAIL st_retire: got rw=%b alu=%h want rw=0 alu=40", o.rw, o.alu);
      end
   endtask

   task automatic test_ready_at_timeout();
      obs_t o;
      issue(make_instr(1'b1, 1'b1, 1'b0, 5'd9, 32'h200, 32'h0), TO, 32'h600DF00D, 1'b0, o);
      n_checks++;
      if (o.stalls !== 8'(TO)) begin n_fail++; $display("FAIL tie_stalls: got %0d want %0d", o.stalls, TO); end
      n_checks++;
      if (o.err !== 1'b0 || o.rdd !== 32'h600DF00D) begin
         n_fail++; $display("FAIL tie_ready_wins: got err=%b data=%h want err=0 data=600df00d", o.err, o.rdd);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      instr_t nop;
      issue(make_instr(1'b1, 1'b1, 1'b0, 5'd3, 32'h300, 32'h0), 1000, 32'hBAD, 1'b0, o);
      exp_err = 1'b1;
      n_checks++;
      if (o.stalls !== 8'(TO) || o.hung !== 1'b0) begin
         n_fail++; $display("FAIL to_stalls: got %0d hung=%b want %0d", o.stalls, o.hung, TO);
      end
      n_checks++;
      if (o.err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err: got %b want 1", o.err); end
      n_checks++;
      if (o.rdd !== '0 || o.rd !== 5'd3) begin
         n_fail++; $display("FAIL to_retire: got data=%h rd=%0d want data=0 rd=3", o.rdd, o.rd);
      end
      nop = make_instr(1'b1, 1'b0, 1'b0, 5'd4, 32'h77, 32'h0);
      issue(nop, 0, 32'h0, 1'b0, o);
      n_checks++;
      if (o.stalls !== 8'd0 || o.rdd !== '0 || o.res !== 32'h77 || o.bus_bad !== 8'd0) begin
         n_fail++;
         $display("FAIL to_late_ready: got stalls=%0d data=%h res=%h bad=%0d want 0/0/77/0",
                  o.stalls, o.rdd, o.res, o.bus_bad);
      end
      n_checks++;
      if (o.err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", o.err); end
   endtask

   task automatic test_reset_in_wait();
      obs_t o;
      RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0;
      ALUResultM = 32'h100; WriteDataM = '0; RDM = 5'd5; PCPlus4M = 32'h10;
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b0;
      #1;
      exp_err = 1'b0;
      n_checks++;
      if (dmem_req !== 1'b0 || StallM !== 1'b0) begin
         n_fail++; $display("FAIL rw_bus_drop: got req=%b stall=%b want 0/0", dmem_req, StallM);
      end
      n_checks++;
      if ({bus_err, fsm_state, RegWriteW, RDW, ResultW, PCPlus4W} !== '0) begin
         n_fail++;
         $display("FAIL rw_outputs: got err=%b st=%b rw=%b rd=%0d res=%h pc4=%h want all 0",
                  bus_err, fsm_state, RegWriteW, RDW, ResultW, PCPlus4W);
      end
      RegWriteM = 1'b0; ResultSrcM = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (fsm_state !== 1'b0 || dmem_req !== 1'b0) begin
         n_fail++; $display("FAIL rw_idle: got st=%b req=%b want 0/0", fsm_state, dmem_req);
      end
      issue(make_instr(1'b1, 1'b1, 1'b0, 5'd6, 32'h104, 32'h0), 0, 32'h13579BDF, 1'b0, o);
      n_checks++;
      if (o.stalls !== 8'd0 || o.res !== 32'h13579BDF) begin
         n_fail++; $display("FAIL rw_after: got stalls=%0d res=%h want 0/13579bdf", o.stalls, o.res);
      end
   endtask

   task automatic test_alu_then_load();
      obs_t o;
      issue(make_instr(1'b1, 1'b0, 1'b0, 5'd7, 32'h55, 32'h0), 0, 32'h0, 1'b0, o);
      n_checks++;
      if (o.res !== 32'h55 || o.rd !== 5'd7 || o.stalls !== 8'd0) begin
         n_fail++; $display("FAIL alu_result: got res=%h rd=%0d stalls=%0d want 55/7/0", o.res, o.rd, o.stalls);
      end
      issue(make_instr(1'b1, 1'b1, 1'b0, 5'd5, 32'h100, 32'h0), 0, 32'h89ABCDEF, 1'b0, o);
      n_checks++;
      if (o.res !== 32'h89ABCDEF || o.stalls !== 8'd0) begin
         n_fail++; $display("FAIL alu_load: got res=%h stalls=%0d want 89abcdef/0", o.res, o.stalls);
      end
   endtask

   task automatic test_random_back_to_back();
      obs_t o;
      instr_t in;
      int k, r;
      logic [DW-1:0] rdata, exp_res, exp_rdd;
      for (int n = 0; n < 60; n++) begin
         in = rand_instr();
         r = $urandom_range(0, 9);
         k = (r < 6) ? (r % 4) : ((r < 8) ? 0 : ((r == 8) ? TO : TO + 5));
         rdata = $urandom;
         exp_rdd = model_rdd(in, k, rdata);
         exp_q.push_back(in.rs ? exp_rdd : in.alu);
         exp_err = exp_err | model_timeout(in, k);
         issue(in, k, rdata, 1'($urandom), o);
         exp_res = exp_q.pop_front();
         n_checks++;
         if (o.stalls !== 8'(model_stalls(in, k)) || o.bubbles !== o.stalls || o.hung !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_stall[%0d]: got stalls=%0d bubbles=%0d hung=%b want %0d",
                     n, o.stalls, o.bubbles, o.hung, model_stalls(in, k));
         end
         n_checks++;
         if (o.res !== exp_res || o.rdd !== exp_rdd) begin
            n_fail++; $display("FAIL rnd_result[%0d]: got res=%h data=%h want %h/%h", n, o.res, o.rdd, exp_res, exp_rdd);
         end
         n_checks++;
         if (o.rw !== in.rw || o.rs !== in.rs || o.rd !== in.rd || o.pc4 !== in.pc4) begin
            n_fail++; $display("FAIL rnd_ctrl[%0d]: got rw=%b rs=%b rd=%0d pc4=%h", n, o.rw, o.rs, o.rd, o.pc4);
         end
         n_checks++;
         if (o.err !== exp_err || o.bus_bad !== 8'd0) begin
            n_fail++; $display("FAIL rnd_bus[%0d]: got err=%b bad=%0d want err=%b bad=0", n, o.err, o.bus_bad, exp_err);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_wait_load();
      test_wait_load();
      test_store_perturbed();
      test_alu_then_load();
      test_ready_at_timeout();
      test_timeout();
      test_reset_in_wait();
      test_random_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
